// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback port arbiter.
// The entry layout fixes XLEN/TAG_W; the arbiter's parameters default to these.
package wb_pkg;

    localparam int         WB_XLEN  = 32;
    localparam int         WB_TAG_W = 4;
    localparam logic [4:0] RD_ZERO  = 5'd0;

    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [WB_TAG_W-1:0] tag;
        logic [WB_XLEN-1:0]  data;
    } wb_entry_t;

    // a_tag is older than b_tag when b_tag is ahead by less than half the tag space.
    function automatic logic is_older(input logic [WB_TAG_W-1:0] a_tag,
                                      input logic [WB_TAG_W-1:0] b_tag);
        logic [WB_TAG_W-1:0] diff;
        diff = b_tag - a_tag;
        return (diff != '0) && !diff[WB_TAG_W-1];
    endfunction

endpackage

// File: rtl/wb_pend_queue.sv
// In-order circular buffer of pending ALU writebacks, with an rd/tag
// match-and-clear squash port that also covers the entry being pushed.
module wb_pend_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  wb_entry_t              i_pushEntry,
    input  logic                   i_pop,
    input  logic                   i_sqVld,
    input  logic [4:0]             i_sqRd,
    input  logic [WB_TAG_W-1:0]    i_sqTag,
    output wb_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_cnt;
    wb_entry_t        w_pushEntry;

    always_comb begin
        w_pushEntry = i_pushEntry;
        if (i_sqVld && (i_pushEntry.rd == i_sqRd) && is_older(i_pushEntry.tag, i_sqTag)) begin
            w_pushEntry.valid = 1'b0;
        end
    end

    // Squashed entries keep their slot; the arbiter pops them without writing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_sqVld && r_mem[i].valid && (r_mem[i].rd == i_sqRd) &&
                    is_older(r_mem[i].tag, i_sqTag)) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
            if (i_push) begin
                r_mem[r_wrPtr] <= w_pushEntry;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head = r_mem[r_rdPtr];
    assign o_cnt  = r_cnt;

    a_noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && (r_cnt == CNT_W'(DEPTH))));

endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the regfile write port: load returns always win, colliding ALU results
// wait in an in-order queue, and stale queued results are squashed by age tag.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int DEPTH = 4,
    parameter int TAG_W = WB_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   alu_vld,
    output logic                   alu_rdy,
    input  logic [4:0]             alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic [TAG_W-1:0]       alu_tag,
    input  logic                   ld_vld,
    input  logic [4:0]             ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    input  logic [TAG_W-1:0]       ld_tag,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [$clog2(DEPTH):0] q_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             w_aluAcc;
    logic             w_qEmpty;
    logic             w_push;
    logic             w_pop;
    logic             w_sqVld;
    logic             w_nextWe;
    logic [4:0]       w_nextAddr;
    logic [XLEN-1:0]  w_nextData;
    logic [CNT_W-1:0] w_cnt;
    wb_entry_t        w_head;
    wb_entry_t        w_aluEntry;

    // Ready comes from the registered count, so a full queue never pushes.
    assign alu_rdy    = (w_cnt != CNT_W'(DEPTH));
    assign w_aluAcc   = alu_vld && alu_rdy && !flush;
    assign w_qEmpty   = (w_cnt == '0);
    assign w_sqVld    = ld_vld && (ld_rd != RD_ZERO);
    assign w_aluEntry = '{valid: 1'b1, rd: alu_rd, tag: alu_tag, data: alu_data};
    assign q_cnt      = w_cnt;

    wb_pend_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_push     (w_push),
        .i_pushEntry(w_aluEntry),
        .i_pop      (w_pop),
        .i_sqVld    (w_sqVld),
        .i_sqRd     (ld_rd),
        .i_sqTag    (ld_tag),
        .o_head     (w_head),
        .o_cnt      (w_cnt)
    );

    always_comb begin
        w_nextWe   = 1'b0;
        w_nextAddr = rf_waddr;
        w_nextData = rf_wdata;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        if (ld_vld) begin
            w_nextWe   = (ld_rd != RD_ZERO);
            w_nextAddr = ld_rd;
            w_nextData = ld_data;
            w_push     = w_aluAcc;
        end else if (!w_qEmpty) begin
            w_pop      = 1'b1;
            w_nextWe   = w_head.valid && (w_head.rd != RD_ZERO);
            w_nextAddr = w_head.rd;
            w_nextData = w_head.data;
            w_push     = w_aluAcc;
        end else if (w_aluAcc) begin
            w_nextWe   = (alu_rd != RD_ZERO);
            w_nextAddr = alu_rd;
            w_nextData = alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= w_nextWe;
            rf_waddr <= w_nextAddr;
            rf_wdata <= w_nextData;
        end
    end

endmodule
